// File: rtl/lcd_pkg.sv
// Shared types and the solid-fill colour table for the LCD test-pattern scheduler.
package lcd_pkg;

  typedef enum logic [1:0] {PAT_BARS, PAT_SOLID, PAT_CHECK, PAT_GRAD} pattern_e;

  typedef enum logic [1:0] {IDLE, AUTO, MAN} sched_state_e;

  localparam logic [2:0] COLOUR_LAST = 3'd6;

  // {R,G,B}: white, yellow, cyan, green, magenta, red, blue
  localparam logic [23:0] COLOUR_LUT [0:6] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF
  };

  function automatic logic [23:0] colour_of(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd1:    rgb = COLOUR_LUT[1];
      3'd2:    rgb = COLOUR_LUT[2];
      3'd3:    rgb = COLOUR_LUT[3];
      3'd4:    rgb = COLOUR_LUT[4];
      3'd5:    rgb = COLOUR_LUT[5];
      3'd6:    rgb = COLOUR_LUT[6];
      default: rgb = COLOUR_LUT[0];
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/lcd_frame_edge.sv
// Registers active-low VD and flags its falling edge as a one-cycle frame boundary (fb).
module lcd_frame_edge (
  input  logic clk,
  input  logic rst,
  input  logic vd,
  output logic fb
);

  logic vd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vd_q <= 1'b1;
    end else begin
      vd_q <= vd;
    end
  end

  assign fb = vd_q & ~vd;

endmodule

// File: rtl/lcd_pattern_sched.sv
// Frame-synchronous test-pattern scheduler: auto or manual advance, applied only at VD falls.
// Optional macro LCD_SCHED_FREEZE_EN adds a FREEZE input that suspends frame-boundary updates.
module lcd_pattern_sched
  import lcd_pkg::*;
#(
  parameter int unsigned FRAMES_PER_PATTERN = 60,
  parameter int unsigned NUM_PATTERNS       = 4,
  parameter int unsigned CNT_W              = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VD,
  input  logic             MODE_AUTO,
  input  logic             BTN_NEXT,
`ifdef LCD_SCHED_FREEZE_EN
  input  logic             FREEZE,
`endif
  output logic [1:0]       PAT_SEL,
  output logic [23:0]      SOLID_RGB,
  output logic [CNT_W-1:0] FRAME_CNT,
  output logic             SWITCHING
);

  localparam logic [1:0]       LAST_PAT = 2'(NUM_PATTERNS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAMES_PER_PATTERN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic fb_raw, fb;

  lcd_frame_edge u_frame_edge (
    .clk (CLK),
    .rst (RST),
    .vd  (VD),
    .fb  (fb_raw)
  );

`ifdef LCD_SCHED_FREEZE_EN
  assign fb = fb_raw & ~FREEZE;
`else
  assign fb = fb_raw;
`endif

  sched_state_e     state_q, state_d;
  logic [1:0]       pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       col_q, col_d;
  logic             pend_q, pend_d;
  logic             sw_q, sw_d;
  logic             adv;

  // The current state's advance rule is evaluated on a mode-change fb; the counter is then cleared.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    pend_d  = pend_q;
    sw_d    = 1'b0;
    adv     = 1'b0;

    unique case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (fb) begin
          state_d = MODE_AUTO ? AUTO : MAN;
          cnt_d   = '0;
        end
      end
      AUTO: begin
        pend_d = 1'b0;
        if (fb) begin
          if (cnt_q == LAST_CNT) begin
            adv   = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          if (!MODE_AUTO) begin
            state_d = MAN;
            cnt_d   = '0;
          end
        end
      end
      MAN: begin
        if (fb) begin
          pend_d = 1'b0;
          if (pend_q | BTN_NEXT) begin
            adv   = 1'b1;
            cnt_d = '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (MODE_AUTO) begin
            state_d = AUTO;
            cnt_d   = '0;
          end
        end else if (BTN_NEXT) begin
          pend_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (adv) begin
      sw_d  = 1'b1;
      pat_d = (pat_q == LAST_PAT) ? 2'd0 : pat_q + 2'd1;
      if (pat_d == PAT_SOLID) begin
        col_d = (col_q == COLOUR_LAST) ? 3'd0 : col_q + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      pat_q   <= 2'd0;
      cnt_q   <= '0;
      col_q   <= 3'd0;
      pend_q  <= 1'b0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      pend_q  <= pend_d;
      sw_q    <= sw_d;
    end
  end

  assign PAT_SEL   = pat_q;
  assign SOLID_RGB = colour_of(col_q);
  assign FRAME_CNT = cnt_q;
  assign SWITCHING = sw_q;

endmodule
